// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: write-back pipeline register with a one-entry skid buffer and stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [ADDR_W-1:0] in_write_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] write_addr;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  entry_t head, skid, in_e;
  logic in_xfer, out_xfer, load_head, load_skid;
  assign in_e = {in_reg_write, in_mem_to_reg, in_read_data, in_alu_result, in_write_addr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (in_xfer ? ONE : EMPTY) :
               state == ONE ? ((in_xfer && !out_xfer) ? FULL : (!in_xfer && out_xfer) ? EMPTY : ONE) :
               (out_ready ? ONE : FULL);
  end
  // in_ready depends only on the registered state, never on out_ready
  always_comb begin
    in_ready  = state != FULL;
    out_valid = state != EMPTY;
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    load_head = !flush && ((state == EMPTY && in_xfer) || (state == ONE && in_xfer && out_xfer) ||
                           (state == FULL && out_ready));
    load_skid = !flush && state == ONE && in_xfer && !out_xfer;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head) head <= (state == FULL) ? skid : in_e;
      if (load_skid) skid <= in_e;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
  assign out_reg_write  = head.reg_write & out_valid;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_read_data  = head.read_data;
  assign out_alu_result = head.alu_result;
  assign out_write_addr = head.write_addr;
  assign wb_data        = head.mem_to_reg ? head.read_data : head.alu_result;
endmodule
